pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying payload/PC/Tnew/exception/BD with
// flush > stall > bubble > load priority and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int TNEW_W = 2,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_payload,
  input  logic [31:0]       in_pc,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  local_exc,
  input  logic              in_bd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_payload,
  output logic [31:0]       out_pc,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  out_bubble_cnt,
  output logic [CNT_W-1:0]  out_stall_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [31:0]       pc_q, pc_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              bd_q, bd_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    pc_d      = pc_q;
    tnew_d    = tnew_q;
    exc_d     = exc_q;
    bd_d      = bd_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    if (flush) begin
      valid_d   = 1'b0;
      payload_d = '0;
      pc_d      = '0;
      tnew_d    = '0;
      exc_d     = '0;
      bd_d      = 1'b0;
    end else if (stall) begin
      if (scnt_q != {CNT_W{1'b1}}) scnt_d = scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (bubble) begin
      // NOP inserted, but PC/BD follow the upstream slot for EPC reporting
      valid_d   = 1'b0;
      payload_d = '0;
      tnew_d    = '0;
      exc_d     = '0;
      pc_d      = in_pc;
      bd_d      = in_bd;
      if (bcnt_q != {CNT_W{1'b1}}) bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      valid_d   = in_valid;
      payload_d = in_payload;
      pc_d      = in_pc;
      bd_d      = in_bd;
      tnew_d    = '0;
      exc_d     = '0;
      if (in_valid) begin
        if (in_tnew != '0) tnew_d = in_tnew - {{(TNEW_W-1){1'b0}}, 1'b1};
        exc_d = (in_exc != '0) ? in_exc : local_exc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      pc_q      <= '0;
      tnew_q    <= '0;
      exc_q     <= '0;
      bd_q      <= 1'b0;
      bcnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      pc_q      <= pc_d;
      tnew_q    <= tnew_d;
      exc_q     <= exc_d;
      bd_q      <= bd_d;
      bcnt_q    <= bcnt_d;
      scnt_q    <= scnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_payload    = payload_q;
  assign out_pc         = pc_q;
  assign out_tnew       = tnew_q;
  assign out_exc        = exc_q;
  assign out_bd         = bd_q;
  assign out_bubble_cnt = bcnt_q;
  assign out_stall_cnt  = scnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: expected stage contents queued at drive
// time, popped and compared one edge later; directed vectors plus random traffic.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int EW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, stall, bubble, in_valid, in_bd;
  logic [DW-1:0] in_payload;
  logic [31:0]   in_pc;
  logic [TW-1:0] in_tnew;
  logic [EW-1:0] in_exc, local_exc;
  logic          out_valid, out_bd;
  logic [DW-1:0] out_payload;
  logic [31:0]   out_pc;
  logic [TW-1:0] out_tnew;
  logic [EW-1:0] out_exc;
  logic [CW-1:0] out_bubble_cnt, out_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .EXC_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .in_tnew(in_tnew), .in_exc(in_exc), .local_exc(local_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_payload(out_payload), .out_pc(out_pc),
    .out_tnew(out_tnew), .out_exc(out_exc), .out_bd(out_bd),
    .out_bubble_cnt(out_bubble_cnt), .out_stall_cnt(out_stall_cnt)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] payload;
    logic [31:0]   pc;
    logic [TW-1:0] tnew;
    logic [EW-1:0] exc;
    logic          bd;
    logic [CW-1:0] bc;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"},   64'(out_valid),      64'(e.valid));
    chk({tag, ".payload"}, 64'(out_payload),    64'(e.payload));
    chk({tag, ".pc"},      64'(out_pc),         64'(e.pc));
    chk({tag, ".tnew"},    64'(out_tnew),       64'(e.tnew));
    chk({tag, ".exc"},     64'(out_exc),        64'(e.exc));
    chk({tag, ".bd"},      64'(out_bd),         64'(e.bd));
    chk({tag, ".bcnt"},    64'(out_bubble_cnt), 64'(e.bc));
    chk({tag, ".scnt"},    64'(out_stall_cnt),  64'(e.sc));
  endtask

  function automatic exp_t zero_st();
    exp_t z;
    z.valid = 0; z.payload = '0; z.pc = '0; z.tnew = '0;
    z.exc = '0; z.bd = 0; z.bc = '0; z.sc = '0;
    return z;
  endfunction

  // Drive one cycle of inputs, predict the next stage contents, compare after the edge.
  task automatic step(input string tag, input logic f, input logic s, input logic b,
                      input logic v, input logic [DW-1:0] pl, input logic [31:0] pc,
                      input logic [TW-1:0] tn, input logic [EW-1:0] ex,
                      input logic [EW-1:0] lex, input logic bd);
    exp_t n;
    exp_t e;
    flush = f; stall = s; bubble = b; in_valid = v; in_payload = pl; in_pc = pc;
    in_tnew = tn; in_exc = ex; local_exc = lex; in_bd = bd;
    n = m;
    if (f) begin
      n.valid = 0; n.payload = '0; n.pc = '0; n.tnew = '0; n.exc = '0; n.bd = 0;
    end else if (s) begin
      n.sc = (m.sc == 4'hF) ? 4'hF : m.sc + 4'd1;
    end else if (b) begin
      n.valid = 0; n.payload = '0; n.tnew = '0; n.exc = '0; n.pc = pc; n.bd = bd;
      n.bc = (m.bc == 4'hF) ? 4'hF : m.bc + 4'd1;
    end else begin
      n.valid = v; n.payload = pl; n.pc = pc; n.bd = bd;
      n.tnew = (!v || tn == 0) ? 2'd0 : tn - 2'd1;
      n.exc  = !v ? 5'd0 : ((ex != 0) ? ex : lex);
    end
    exp_q.push_back(n);
    m = n;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk_all(tag, e);
  endtask

  task automatic load(input string tag, input logic [31:0] pc, input logic [TW-1:0] tn,
                      input logic [EW-1:0] ex, input logic [EW-1:0] lex);
    step(tag, 0, 0, 0, 1, $urandom, pc, tn, ex, lex, 0);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
  task automatic rst_pulse(input string tag);
    reset = 1'b1;
    #1;
    m = zero_st();
    chk_all(tag, m);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 0; stall = 0; bubble = 0; in_valid = 0; in_bd = 0;
    in_payload = '0; in_pc = '0; in_tnew = '0; in_exc = '0; local_exc = '0;
    m = zero_st();
    #2;
    chk_all("reset", m);
    // inputs active during reset must be ignored
    in_valid = 1; in_pc = 32'hDEAD; stall = 1;
    @(posedge clk); #1;
    chk_all("reset_hold", m);
    reset = 1'b0; stall = 0;

    load("ld35", 32'h3000, 2'd2, 5'd0, 5'd4);
    chk("req35_pc", 64'(out_pc), 64'h3000);
    chk("req35_tnew", 64'(out_tnew), 64'd1);
    chk("req35_exc", 64'(out_exc), 64'd4);
    chk("req35_valid", 64'(out_valid), 64'd1);

    load("tn0", 32'h3004, 2'd0, 5'd0, 5'd0);
    chk("req36_tn0", 64'(out_tnew), 64'd0);
    load("tn3", 32'h3008, 2'd3, 5'd0, 5'd0);
    chk("req36_tn3", 64'(out_tnew), 64'd2);
    load("excprio", 32'h300C, 2'd1, 5'd3, 5'd4);
    chk("exc_earliest", 64'(out_exc), 64'd3);
    step("inval", 0, 0, 0, 0, 32'hAA55, 32'h3010, 2'd3, 5'd6, 5'd7, 1);
    chk("inval_tnew", 64'(out_tnew), 64'd0);
    chk("inval_exc", 64'(out_exc), 64'd0);
    chk("inval_pc", 64'(out_pc), 64'h3010);

    load("pre_bub", 32'h3004, 2'd2, 5'd0, 5'd2);
    step("bubble", 0, 0, 1, 1, 32'h1234, 32'h3008, 2'd3, 5'd1, 5'd1, 1);
    chk("req37_valid", 64'(out_valid), 64'd0);
    chk("req37_payload", 64'(out_payload), 64'd0);
    chk("req37_exc", 64'(out_exc), 64'd0);
    chk("req37_pc", 64'(out_pc), 64'h3008);
    chk("req37_bd", 64'(out_bd), 64'd1);
    chk("req37_bcnt", 64'(out_bubble_cnt), 64'd1);

    load("pre_stall", 32'h4000, 2'd2, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 0, 1, $urandom, $urandom, 2'd3, 5'd9, 5'd9, 1);
    step("stall_bub", 0, 1, 1, 1, $urandom, $urandom, 2'd3, 5'd9, 5'd9, 1);
    chk("req38_tnew", 64'(out_tnew), 64'd1);
    chk("req38_pc", 64'(out_pc), 64'h4000);
    chk("req38_scnt", 64'(out_stall_cnt), 64'd4);
    chk("req38_bcnt", 64'(out_bubble_cnt), 64'd1);

    step("flush_all", 1, 1, 1, 1, $urandom, 32'h5000, 2'd2, 5'd3, 5'd3, 1);
    chk("req39_valid", 64'(out_valid), 64'd0);
    chk("req39_pc", 64'(out_pc), 64'd0);
    chk("req39_scnt", 64'(out_stall_cnt), 64'd4);
    chk("req39_bcnt", 64'(out_bubble_cnt), 64'd1);

    for (int i = 0; i < 20; i++)
      step("sat_s", 0, 1, 0, 0, '0, '0, '0, '0, '0, 0);
    chk("req40_scnt", 64'(out_stall_cnt), 64'd15);
    for (int i = 0; i < 20; i++)
      step("sat_b", 0, 0, 1, 0, '0, 32'h10, '0, '0, '0, 0);
    chk("bcnt_sat", 64'(out_bubble_cnt), 64'd15);

    // reset during a stall with live contents
    load("pre_rst", 32'h6000, 2'd3, 5'd2, 5'd0);
    stall = 1;
    rst_pulse("rst_mid");
    step("post_rst_stall", 0, 1, 0, 1, 32'h77, 32'h6004, 2'd1, 5'd0, 5'd0, 0);
    load("post_rst_ld", 32'h6008, 2'd1, 5'd0, 5'd5);

    for (int i = 0; i < 300; i++) begin
      logic f, s, b;
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      if (i % 97 == 50) rst_pulse("rnd_rst");
      step("rnd", f, s, b, 1'($urandom), $urandom, $urandom, 2'($urandom),
           ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0, 5'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
